// File: rtl/memory_dp_param.sv
// Parametrised simple-dual-port RAM: one write port, one read port, a post-reset clear sequencer,
// a read-valid strobe and a selectable read-during-write policy. Define MEM_OUTPUT_REG_EN for a second output stage.
module memory_dp_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_wen,
  input  logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_data_valid,
  output logic                  mem_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_clear_addr;
  logic                    w_clear_last;

  logic                    w_arr_we;
  logic [ADDR_WIDTH-1:0]   w_arr_addr;
  logic [DATA_WIDTH-1:0]   w_arr_wdata;
  logic                    w_rd_en;
  logic                    w_rdw_hit;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_data_s1;
  logic                    r_valid_s1;

  assign w_clear_last = (r_clear_addr == {ADDR_WIDTH{1'b1}});

  // NOTE: sequential state is only ever assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= CLEAR;
      r_clear_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) begin
        r_clear_addr <= r_clear_addr + 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_arr_we     = 1'b0;
    w_arr_addr   = mem_waddr;
    w_arr_wdata  = mem_data_in;
    w_rd_en      = 1'b0;
    unique case (r_state)
      CLEAR: begin
        // The sequencer owns the array; user enables are ignored.
        w_arr_we    = ~reset;
        w_arr_addr  = r_clear_addr;
        w_arr_wdata = '0;
        if (w_clear_last) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_arr_we = mem_wen & ~reset;
        w_rd_en  = mem_ren;
      end
      default: w_state_next = CLEAR;
    endcase
  end

  // NOTE: the array has no reset so it can map onto block RAM; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (w_arr_we) begin
      r_mem[w_arr_addr] <= w_arr_wdata;
    end
  end

  // The array read sees pre-write contents (read-first); write-through forwards the incoming word.
  assign w_rdw_hit = mem_wen && (mem_waddr == mem_raddr);

  always_comb begin
    w_rd_word = r_mem[mem_raddr];
    if ((RDW_MODE != 0) && w_rdw_hit) begin
      w_rd_word = mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_s1  <= '0;
      r_valid_s1 <= 1'b0;
    end else begin
      r_valid_s1 <= w_rd_en;
      if (w_rd_en) begin
        r_data_s1 <= w_rd_word;
      end
    end
  end

`ifdef MEM_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] r_data_s2;
  logic                  r_valid_s2;

  // Second stage loads only on a valid first stage so held data survives idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_s2  <= '0;
      r_valid_s2 <= 1'b0;
    end else begin
      r_valid_s2 <= r_valid_s1;
      if (r_valid_s1) begin
        r_data_s2 <= r_data_s1;
      end
    end
  end

  assign mem_data_out   = r_data_s2;
  assign mem_data_valid = r_valid_s2;
`else
  assign mem_data_out   = r_data_s1;
  assign mem_data_valid = r_valid_s1;
`endif

  assign mem_busy = (r_state == CLEAR);

endmodule

// File: tb/tb_memory_dp_param.sv
// Directed bench for memory_dp_param: a default instance (read-first) and a 32x64 write-through instance.
module tb_memory_dp_param;

`ifdef MEM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: defaults, read-first.
  logic        a_reset = 1'b1;
  logic [9:0]  a_waddr = '0, a_raddr = '0;
  logic [7:0]  a_din = '0, a_dout;
  logic        a_wen = 1'b0, a_ren = 1'b0, a_valid, a_busy;

  memory_dp_param u_dut_a (
    .clk(clk), .reset(a_reset),
    .mem_waddr(a_waddr), .mem_raddr(a_raddr), .mem_data_in(a_din),
    .mem_wen(a_wen), .mem_ren(a_ren),
    .mem_data_out(a_dout), .mem_data_valid(a_valid), .mem_busy(a_busy)
  );

  // Instance B: 32-bit words, 64 deep, write-through.
  logic        b_reset = 1'b1;
  logic [5:0]  b_waddr = '0, b_raddr = '0;
  logic [31:0] b_din = '0, b_dout;
  logic        b_wen = 1'b0, b_ren = 1'b0, b_valid, b_busy;

  memory_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(1)) u_dut_b (
    .clk(clk), .reset(b_reset),
    .mem_waddr(b_waddr), .mem_raddr(b_raddr), .mem_data_in(b_din),
    .mem_wen(b_wen), .mem_ren(b_ren),
    .mem_data_out(b_dout), .mem_data_valid(b_valid), .mem_busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_clear_a(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (a_busy && n < 5000);
  endtask

  task automatic write_a(input logic [9:0] addr, input logic [7:0] data);
    a_wen = 1'b1; a_waddr = addr; a_din = data;
    step();
    a_wen = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [9:0] addr, input logic [7:0] exp);
    a_ren = 1'b1; a_raddr = addr;
    step();
    a_ren = 1'b0;
    repeat (LAT - 1) step();
    check({tag, "_data"}, a_dout, exp);
    check({tag, "_valid"}, a_valid, 1'b1);
    step();
    check({tag, "_valid_drop"}, a_valid, 1'b0);
  endtask

  task automatic write_b(input logic [5:0] addr, input logic [31:0] data);
    b_wen = 1'b1; b_waddr = addr; b_din = data;
    step();
    b_wen = 1'b0;
  endtask

  task automatic read_b(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    b_ren = 1'b1; b_raddr = addr;
    step();
    b_ren = 1'b0;
    repeat (LAT - 1) step();
    check({tag, "_data"}, b_dout, exp);
    check({tag, "_valid"}, b_valid, 1'b1);
    step();
    check({tag, "_valid_drop"}, b_valid, 1'b0);
  endtask

  initial begin
    int n;
    logic saw_valid;

    // ---------------- instance A ----------------
    step(); step();
    check("a_rst_busy", a_busy, 1'b1);
    check("a_rst_dout", a_dout, 8'h00);
    check("a_rst_valid", a_valid, 1'b0);

    a_reset = 1'b0;
    count_clear_a(n);
    check("a_clear_len", n, 1024);

    read_a("a_rd000", 10'h000, 8'h00);
    read_a("a_rd155", 10'h155, 8'h00);
    read_a("a_rd3ff", 10'h3FF, 8'h00);

    write_a(10'h3FF, 8'h3C);
    read_a("a_wr_rd3ff", 10'h3FF, 8'h3C);

    // Same-address read-during-write: read-first returns the old word.
    write_a(10'h010, 8'hAA);
    a_wen = 1'b1; a_waddr = 10'h010; a_din = 8'h55;
    a_ren = 1'b1; a_raddr = 10'h010;
    step();
    a_wen = 1'b0; a_ren = 1'b0;
    repeat (LAT - 1) step();
    check("a_rdw_old", a_dout, 8'hAA);
    read_a("a_rdw_follow", 10'h010, 8'h55);

    // Different-address write and read in one cycle stay independent.
    a_wen = 1'b1; a_waddr = 10'h011; a_din = 8'h99;
    a_ren = 1'b1; a_raddr = 10'h3FF;
    step();
    a_wen = 1'b0; a_ren = 1'b0;
    repeat (LAT - 1) step();
    check("a_indep_rd", a_dout, 8'h3C);
    read_a("a_indep_wr", 10'h011, 8'h99);

    // Streaming reads, one per cycle.
    for (int i = 0; i < 16; i++) write_a(10'(i), 8'(i));
    for (int c = 0; c < 16 + LAT - 1; c++) begin
      a_ren = (c < 16); a_raddr = 10'(c);
      step();
      if (c >= LAT - 1) begin
        check($sformatf("a_stream%0d_data", c - (LAT - 1)), a_dout, 64'(c - (LAT - 1)));
        check($sformatf("a_stream%0d_valid", c - (LAT - 1)), a_valid, 1'b1);
      end
    end
    a_ren = 1'b0;
    step();
    check("a_hold_data", a_dout, 8'h0F);
    check("a_hold_valid", a_valid, 1'b0);

    write_a(10'h155, 8'h77);

    // Reset in RUN with a read in flight: strobe dropped, data cleared.
    a_ren = 1'b1; a_raddr = 10'h3FF;
    if (LAT == 2) begin
      step();
      a_ren = 1'b0;
    end
    a_reset = 1'b1;
    step();
    a_ren = 1'b0;
    check("a_runrst_valid", a_valid, 1'b0);
    check("a_runrst_dout", a_dout, 8'h00);
    check("a_runrst_busy", a_busy, 1'b1);

    // Reset again at clear cycle 500: the clear restarts from address 0.
    a_reset = 1'b0;
    repeat (500) step();
    check("a_mid_busy", a_busy, 1'b1);
    a_reset = 1'b1;
    step();
    check("a_mid_rst_busy", a_busy, 1'b1);
    a_reset = 1'b0;
    count_clear_a(n);
    check("a_reclear_len", n, 1024);
    read_a("a_cleared155", 10'h155, 8'h00);
    read_a("a_cleared3ff", 10'h3FF, 8'h00);

    // ---------------- instance B ----------------
    // Enables held high during the clear must be ignored.
    b_wen = 1'b1; b_waddr = 6'd63; b_din = 32'h1234_5678;
    b_ren = 1'b1; b_raddr = 6'd63;
    b_reset = 1'b0;
    n = 0;
    saw_valid = 1'b0;
    do begin
      step();
      n++;
      if (b_valid) saw_valid = 1'b1;
    end while (b_busy && n < 500);
    b_wen = 1'b0; b_ren = 1'b0;
    check("b_clear_len", n, 64);
    check("b_clear_no_valid", saw_valid, 1'b0);
    read_b("b_clear_wr_ignored", 6'd63, 32'h0);

    write_b(6'd63, 32'hDEAD_BEEF);
    read_b("b_rd63", 6'd63, 32'hDEAD_BEEF);

    // Same-address read-during-write: write-through returns the new word.
    write_b(6'd5, 32'h0000_00AA);
    b_wen = 1'b1; b_waddr = 6'd5; b_din = 32'h0000_0055;
    b_ren = 1'b1; b_raddr = 6'd5;
    step();
    b_wen = 1'b0; b_ren = 1'b0;
    repeat (LAT - 1) step();
    check("b_rdw_new", b_dout, 32'h0000_0055);
    read_b("b_rdw_follow", 6'd5, 32'h0000_0055);

    b_wen = 1'b1; b_waddr = 6'd6; b_din = 32'hCAFE_0001;
    b_ren = 1'b1; b_raddr = 6'd63;
    step();
    b_wen = 1'b0; b_ren = 1'b0;
    repeat (LAT - 1) step();
    check("b_indep_rd", b_dout, 32'hDEAD_BEEF);
    read_b("b_indep_wr", 6'd6, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
